// File: rtl/execute_md_pipe.sv
// ---------------------------------------------------------------------------
// execute_md_pipe
//
// Execute stage sitting between decode/register-read and the memory stage.
// Single-cycle ALU ops (ADD/SUB/AND/OR/SLL/SRA) go straight into the X/M
// pipeline register. MUL/DIV are handed to an iterative signed unit that
// works on operand magnitudes, one bit per cycle, and holds decode off with
// 'stall' until the result is ready.
//
// Ports
//   clock, aclr          rising-edge clock, synchronous active-low reset
//   in_valid             decode presents an instruction this cycle
//   rdata_a/rdata_b      register-file operands
//   mw_data              M/W forwarding data
//   fwd_a_sel/fwd_b_sel  0 regfile, 1 mw_data, 2 xm_result, 3 regfile
//   imm, alu_src         immediate; alu_src=1 selects imm for B and forces ADD
//   alu_op, shamt        0 ADD 1 SUB 2 AND 3 OR 4 SLL 5 SRA 6 MUL 7 DIV
//   rd, reg_wr           destination register and writeback enable
//   stall                decode must hold its instruction
//   xm_*                 X/M pipeline register contents
// ---------------------------------------------------------------------------
module execute_md_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int RD_W    = 5,
    parameter int CNT_W   = 6
) (
    input  logic               clock,
    input  logic               aclr,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   rdata_a,
    input  logic [WIDTH-1:0]   rdata_b,
    input  logic [WIDTH-1:0]   mw_data,
    input  logic [1:0]         fwd_a_sel,
    input  logic [1:0]         fwd_b_sel,
    input  logic [WIDTH-1:0]   imm,
    input  logic               alu_src,
    input  logic [4:0]         alu_op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [RD_W-1:0]    rd,
    input  logic               reg_wr,
    output logic               stall,
    output logic               xm_valid,
    output logic [WIDTH-1:0]   xm_result,
    output logic [RD_W-1:0]    xm_rd,
    output logic               xm_reg_wr,
    output logic               xm_ne,
    output logic               xm_lt,
    output logic               xm_divz
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state;

    // ---------------- operand selection ----------------
    logic [WIDTH-1:0] opA, opBFwd, opB, aluRes;
    logic [4:0]       effOp;
    logic             aluNe, aluLt, isMd, isDiv, startMd;

    always_comb begin
        case (fwd_a_sel)
            2'd1:    opA = mw_data;
            2'd2:    opA = xm_result;
            default: opA = rdata_a;
        endcase
        case (fwd_b_sel)
            2'd1:    opBFwd = mw_data;
            2'd2:    opBFwd = xm_result;
            default: opBFwd = rdata_b;
        endcase
    end

    assign opB   = alu_src ? imm : opBFwd;
    assign effOp = alu_src ? OP_ADD : alu_op;
    assign aluNe = (opA != opB);
    assign aluLt = ($signed(opA) < $signed(opB));

    always_comb begin
        case (effOp)
            OP_ADD:  aluRes = opA + opB;
            OP_SUB:  aluRes = opA - opB;
            OP_AND:  aluRes = opA & opB;
            OP_OR:   aluRes = opA | opB;
            OP_SLL:  aluRes = opA << shamt;
            OP_SRA:  aluRes = $unsigned($signed(opA) >>> shamt);
            default: aluRes = '0;   // MUL/DIV never take this path
        endcase
    end

    // alu_src forces ADD, so an immediate-form MUL/DIV is just an add.
    assign isDiv   = (alu_op == OP_DIV);
    assign isMd    = !alu_src && ((alu_op == OP_MUL) || isDiv);
    assign startMd = in_valid && isMd && (state == IDLE);

    // Stall covers the accepting IDLE cycle and every BUSY cycle. DONE drops
    // it so decode moves past the held instruction.
    assign stall = aclr && (startMd || (state == BUSY));

    // ---------------- iterative mul/div datapath ----------------
    // mdQ  : MUL multiplier (shifted right) / DIV dividend becoming quotient
    // mdD  : MUL multiplicand (shifted left) / DIV divisor
    // mdAcc: MUL low product bits / DIV partial remainder
    logic [WIDTH-1:0] mdQ, mdD, mdAcc;
    logic             mdDiv, mdNeg, mdDivz;
    logic [CNT_W-1:0] count;
    logic [RD_W-1:0]  latRd;
    logic             latWr, latNe, latLt;

    logic [WIDTH-1:0] absA, absB, mulAcc, mdMag, mdRes;
    logic [WIDTH:0]   shRem;
    logic             divFits;

    assign absA = opA[WIDTH-1]    ? (~opA + 1'b1)    : opA;
    assign absB = opBFwd[WIDTH-1] ? (~opBFwd + 1'b1) : opBFwd;

    // Only the low WIDTH bits of the product are kept, so the accumulator
    // can wrap freely.
    assign mulAcc = mdAcc + (mdQ[0] ? mdD : '0);

    // Restoring step: bring in the next dividend bit and subtract if it fits.
    // The remainder is always below the divisor, so it fits in WIDTH bits.
    assign shRem   = {mdAcc, mdQ[WIDTH-1]};
    assign divFits = (shRem >= {1'b0, mdD});

    assign mdMag = mdDiv ? mdQ : mdAcc;
    assign mdRes = mdDivz ? '0 : (mdNeg ? (~mdMag + 1'b1) : mdMag);

    // ---------------- control + X/M register ----------------
    always_ff @(posedge clock) begin
        if (!aclr) begin
            state     <= IDLE;
            mdQ       <= '0;
            mdD       <= '0;
            mdAcc     <= '0;
            mdDiv     <= 1'b0;
            mdNeg     <= 1'b0;
            mdDivz    <= 1'b0;
            count     <= '0;
            latRd     <= '0;
            latWr     <= 1'b0;
            latNe     <= 1'b0;
            latLt     <= 1'b0;
            xm_valid  <= 1'b0;
            xm_result <= '0;
            xm_rd     <= '0;
            xm_reg_wr <= 1'b0;
            xm_ne     <= 1'b0;
            xm_lt     <= 1'b0;
            xm_divz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startMd) begin
                        mdQ    <= absA;
                        mdD    <= absB;
                        mdAcc  <= '0;
                        mdDiv  <= isDiv;
                        mdNeg  <= opA[WIDTH-1] ^ opBFwd[WIDTH-1];
                        mdDivz <= isDiv && (opBFwd == '0);
                        count  <= CNT_W'(WIDTH);
                        latRd  <= rd;
                        latWr  <= reg_wr;
                        latNe  <= aluNe;
                        latLt  <= aluLt;
                        // Divide by zero skips the iterations entirely.
                        state  <= (isDiv && (opBFwd == '0)) ? DONE : BUSY;
                        xm_valid  <= 1'b0;
                        xm_result <= '0;
                        xm_rd     <= '0;
                        xm_reg_wr <= 1'b0;
                        xm_ne     <= 1'b0;
                        xm_lt     <= 1'b0;
                        xm_divz   <= 1'b0;
                    end else begin
                        xm_valid  <= in_valid;
                        xm_result <= in_valid ? aluRes : '0;
                        xm_rd     <= in_valid ? rd : '0;
                        xm_reg_wr <= in_valid & reg_wr;
                        xm_ne     <= in_valid & aluNe;
                        xm_lt     <= in_valid & aluLt;
                        xm_divz   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mdDiv) begin
                        mdAcc <= divFits ? WIDTH'(shRem - {1'b0, mdD}) : shRem[WIDTH-1:0];
                        mdQ   <= {mdQ[WIDTH-2:0], divFits};
                    end else begin
                        mdAcc <= mulAcc;
                        mdD   <= mdD << 1;
                        mdQ   <= mdQ >> 1;
                    end
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) state <= DONE;
                    xm_valid  <= 1'b0;
                    xm_result <= '0;
                    xm_rd     <= '0;
                    xm_reg_wr <= 1'b0;
                    xm_ne     <= 1'b0;
                    xm_lt     <= 1'b0;
                    xm_divz   <= 1'b0;
                end
                DONE: begin
                    // in_valid is ignored here: whatever decode shows is the
                    // instruction being retired, not a new one.
                    xm_valid  <= 1'b1;
                    xm_result <= mdRes;
                    xm_rd     <= latRd;
                    xm_reg_wr <= latWr;
                    xm_ne     <= latNe;
                    xm_lt     <= latLt;
                    xm_divz   <= mdDivz;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
